rc_multicast_inject: RTL and testbench
======================================

// Module: rc_multicast_inject
// PURPOSE
//  Injection-side flit encoder for the multicast router: the counterpart of the route-compute splitter.
//  Packs a local request (tag, 16-bit destination list, 8-bit payload) into the 30-bit multicast flit.
//  Strips this router's own destination bit and delivers that copy straight to the local sink.
//  Buffers network flits in a DEPTH-entry FIFO and drives them into the router local input port
//  under a valid/ready handshake.
// PARAMETERS
//  DEPTH      4   FIFO entries; must equal 2**WIDTH
//  WIDTH      2   FIFO pointer width
//  DATASIZE   30  flit width
//  router_ID  6   index of this router's bit in the destination list (0..15)
// PORTS
//  rc_clk       in   1   single clock, all state on posedge
//  rst          in   1   reset, synchronous, active-high
//  req_valid    in   1   injection request present
//  req_ready    out  1   request accepted this cycle when req_valid&req_ready
//  req_tag      in   5   header tag -> flit[29:25]
//  req_dst      in   16  destination bitmap -> flit[24:9]
//  req_payload  in   8   payload -> flit[8:1]
//  flit_out     out  30  head-of-FIFO flit {tag,dst,payload,1'b1}
//  flit_valid   out  1   flit_out holds a valid flit
//  flit_ready   in   1   router local port takes flit_out this cycle
//  local_valid  out  1   one-cycle pulse: self-addressed copy delivered
//  local_tag    out  5   tag of the self-addressed copy
//  local_payload out 8   payload of the self-addressed copy
//  drop_cnt     out  8   count of requests with an empty destination list, saturating
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - Pointers and count are cleared; FIFO contents are discarded.
//   - flit_out=0, flit_valid=0, local_valid=0, local_tag=0, local_payload=0, drop_cnt=0.
//   - req_ready=0 while rst is high.
//   - Reset mid-transfer drops every buffered flit and any pending local pulse, with no partial output.
//  Accept
//   - req_ready = !rst && (count != DEPTH).
//   - The full check is independent of whether this request needs a FIFO slot.
//  On accept
//   - self = req_dst[router_ID]; net = req_dst with bit router_ID cleared.
//   - self=1: next cycle local_valid=1, local_tag/local_payload = the request's values.
//     Otherwise local_valid=0. local_tag and local_payload hold their last values.
//   - net!=0: push {req_tag, net, req_payload, 1'b1} at the write pointer; the pointer wraps modulo DEPTH.
//   - net==0 and self=0: no push, no pulse; drop_cnt increments and saturates at 255.
//   - A request with net==0 and self=1 is a local-only delivery; it is not counted as a drop.
//  Output
//   - flit_valid = (count!=0). flit_out is the head entry, or 30'b0 when empty, so bit0=0 means invalid.
//   - Pop when flit_valid && flit_ready; the read pointer wraps modulo DEPTH.
//   - Once flit_valid rises, flit_valid and flit_out stay stable until popped.
//   - Latency: an accept at cycle N into an empty FIFO gives flit_valid=1 at N+1. There is no bypass.
//  Simultaneous push and pop: count is unchanged and both pointers advance.
//   - Under full, no push can occur, because req_ready=0.
//  count width = WIDTH+1, ranging 0..DEPTH.
//   - Push when full and pop when empty cannot occur by construction; assertions check both.
// TESTING
//  1. Reset, then req dst=16'h0101, tag=5'h03, payload=8'hA5, flit_ready=1.
//     -> N+1: flit_out={5'h03,16'h0101,8'hA5,1'b1}, flit_valid=1; popped, then flit_valid=0.
//  2. req dst=16'h0040 (only the router_ID=6 bit), payload=8'h3C.
//     -> local_valid pulses for one cycle with payload 8'h3C; flit_valid stays 0; drop_cnt=0.
//  3. req dst=16'h0041 -> local pulse, and FIFO flit dst=16'h0001.
//  4. flit_ready=0; issue 5 back-to-back reqs.
//     -> 4 are accepted and req_ready=0 on the 5th.
//     -> Then flit_ready=1: flits leave in order, one per cycle; req_ready reasserts after the first pop.
//  5. 300 reqs with dst=0 -> drop_cnt reaches 255 and holds; no flit, no local pulse.
//  6. Fill with 3 flits, pulse rst for 1 cycle -> next cycle flit_valid=0, flit_out=0, drop_cnt=0.
//     -> A new req is then output alone.

Source files
------------

// File: rtl/rc_multicast_inject_if.sv
// Injection-port bundle: request side, network flit side, local sink side and drop counter.
interface rc_multicast_inject_if #(
  parameter int DATASIZE = 30
);
  logic                req_valid;
  logic                req_ready;
  logic [4:0]          req_tag;
  logic [15:0]         req_dst;
  logic [7:0]          req_payload;
  logic [DATASIZE-1:0] flit_out;
  logic                flit_valid;
  logic                flit_ready;
  logic                local_valid;
  logic [4:0]          local_tag;
  logic [7:0]          local_payload;
  logic [7:0]          drop_cnt;

  // Requester / router side: issues requests, takes flits.
  modport master (
    output req_valid, req_tag, req_dst, req_payload, flit_ready,
    input  req_ready, flit_out, flit_valid, local_valid, local_tag,
           local_payload, drop_cnt
  );

  // Encoder side.
  modport slave (
    input  req_valid, req_tag, req_dst, req_payload, flit_ready,
    output req_ready, flit_out, flit_valid, local_valid, local_tag,
           local_payload, drop_cnt
  );
endinterface

// File: rtl/rc_multicast_inject.sv
// Multicast injection encoder: packs local requests into flits, peels off the
// self-addressed copy to the local sink, and queues the network copy in a small FIFO.
module rc_multicast_inject #(
  parameter int DEPTH     = 4,
  parameter int WIDTH     = 2,
  parameter int DATASIZE  = 30,
  parameter int router_ID = 6
) (
  input  logic                   rc_clk,
  input  logic                   rst,
  rc_multicast_inject_if.slave   bus
);

  localparam logic [WIDTH:0] CNT_FULL  = (WIDTH+1)'(DEPTH);
  localparam logic [15:0]    SELF_MASK = 16'(1) << router_ID;

  logic [DATASIZE-1:0] mem_q [DEPTH];
  logic [DATASIZE-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH:0]      count_q, count_d;
  logic                local_valid_q, local_valid_d;
  logic [4:0]          local_tag_q, local_tag_d;
  logic [7:0]          local_payload_q, local_payload_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;

  logic        accept;
  logic        self_hit;
  logic [15:0] net_dst;
  logic        push;
  logic        pop;
  logic        drop;

  // Handshake decode; the full check ignores whether this request needs a slot.
  always_comb begin
    bus.req_ready = !rst && (count_q != CNT_FULL);
    accept        = bus.req_valid && bus.req_ready;
    self_hit      = bus.req_dst[router_ID];
    net_dst       = bus.req_dst & ~SELF_MASK;
    push          = accept && (net_dst != 16'h0);
    drop          = accept && (net_dst == 16'h0) && !self_hit;
    pop           = (count_q != '0) && bus.flit_ready;
  end

  // Next-state for FIFO storage, pointers, local delivery and drop counter.
  always_comb begin
    mem_d           = mem_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    local_valid_d   = 1'b0;
    local_tag_d     = local_tag_q;
    local_payload_d = local_payload_q;
    drop_cnt_d      = drop_cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.req_tag, net_dst, bus.req_payload, 1'b1};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (accept && self_hit) begin
      local_valid_d   = 1'b1;
      local_tag_d     = bus.req_tag;
      local_payload_d = bus.req_payload;
    end

    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Control state register with synchronous reset; buffered flits are abandoned.
  always_ff @(posedge rc_clk) begin
    if (rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      local_valid_q   <= 1'b0;
      local_tag_q     <= '0;
      local_payload_q <= '0;
      drop_cnt_q      <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      local_valid_q   <= local_valid_d;
      local_tag_q     <= local_tag_d;
      local_payload_q <= local_payload_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge rc_clk) begin
    mem_q <= mem_d;
  end

  // Outputs: an empty FIFO presents all-zero so bit0 doubles as a valid marker.
  always_comb begin
    bus.flit_valid    = (count_q != '0);
    bus.flit_out      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    bus.local_valid   = local_valid_q;
    bus.local_tag     = local_tag_q;
    bus.local_payload = local_payload_q;
    bus.drop_cnt      = drop_cnt_q;
  end

  a_no_push_full: assert property (@(posedge rc_clk) disable iff (rst)
    !(push && (count_q == CNT_FULL)));
  a_no_pop_empty: assert property (@(posedge rc_clk) disable iff (rst)
    !(pop && (count_q == '0)));

endmodule

// File: tb/tb_rc_multicast_inject.sv
// Bench for rc_multicast_inject: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rc_multicast_inject;

  logic rc_clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  rc_multicast_inject_if bus ();

  rc_multicast_inject dut (
    .rc_clk (rc_clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 rc_clk = ~rc_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending flits, a pending local copy and a drop tally.
  logic [29:0] mq[$];
  bit          m_lv   = 1'b0;
  logic [4:0]  m_lt   = '0;
  logic [7:0]  m_lp   = '0;
  int          m_drop = 0;

  always @(posedge rc_clk) begin
    bit          acc;
    bit          pp;
    logic [15:0] net;
    if (rst) begin
      mq.delete();
      m_lv   = 1'b0;
      m_lt   = '0;
      m_lp   = '0;
      m_drop = 0;
    end else begin
      acc  = bus.req_valid && (mq.size() < 4);
      pp   = (mq.size() > 0) && bus.flit_ready;
      net  = bus.req_dst & ~16'h0040;
      m_lv = 1'b0;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        if (net != 16'h0) mq.push_back({bus.req_tag, net, bus.req_payload, 1'b1});
        if (bus.req_dst[6]) begin
          m_lv = 1'b1;
          m_lt = bus.req_tag;
          m_lp = bus.req_payload;
        end
        if (net == 16'h0 && !bus.req_dst[6] && m_drop < 255) m_drop++;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge rc_clk) begin
    if (chk_en) begin
      chk("req_ready",     32'(bus.req_ready),     32'(!rst && mq.size() != 4));
      chk("flit_valid",    32'(bus.flit_valid),    32'(mq.size() != 0));
      chk("flit_out",      32'(bus.flit_out),      (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
      chk("local_valid",   32'(bus.local_valid),   32'(m_lv));
      chk("local_tag",     32'(bus.local_tag),     32'(m_lt));
      chk("local_payload", 32'(bus.local_payload), 32'(m_lp));
      chk("drop_cnt",      32'(bus.drop_cnt),      32'(m_drop));
    end
  end

  task automatic cyc();
    @(posedge rc_clk);
    #2;
  endtask

  task automatic set_req(input logic v, input logic [4:0] t, input logic [15:0] d, input logic [7:0] p);
    bus.req_valid   = v;
    bus.req_tag     = t;
    bus.req_dst     = d;
    bus.req_payload = p;
  endtask

  initial begin
    rst = 1'b1;
    set_req(1'b0, 5'h0, 16'h0, 8'h0);
    bus.flit_ready = 1'b0;
    cyc();
    cyc();
    chk_en = 1'b1;
    chk("rst_req_ready",  32'(bus.req_ready),  32'h0);
    chk("rst_flit_valid", 32'(bus.flit_valid), 32'h0);
    chk("rst_flit_out",   32'(bus.flit_out),   32'h0);
    chk("rst_drop_cnt",   32'(bus.drop_cnt),   32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'h1);

    // 1: basic flit, latency one cycle, then popped
    bus.flit_ready = 1'b1;
    set_req(1'b1, 5'h03, 16'h0101, 8'hA5);
    cyc();
    set_req(1'b0, 5'h0, 16'h0, 8'h0);
    chk("t1_flit_valid", 32'(bus.flit_valid), 32'h1);
    chk("t1_flit_out",   32'(bus.flit_out),   32'h0602034B);
    cyc();
    chk("t1_popped", 32'(bus.flit_valid), 32'h0);

    // 2: local-only delivery
    set_req(1'b1, 5'h0A, 16'h0040, 8'h3C);
    cyc();
    set_req(1'b0, 5'h0, 16'h0, 8'h0);
    chk("t2_local_valid",   32'(bus.local_valid),   32'h1);
    chk("t2_local_payload", 32'(bus.local_payload), 32'h3C);
    chk("t2_local_tag",     32'(bus.local_tag),     32'h0A);
    chk("t2_flit_valid",    32'(bus.flit_valid),    32'h0);
    cyc();
    chk("t2_pulse_end", 32'(bus.local_valid),   32'h0);
    chk("t2_hold_pay",  32'(bus.local_payload), 32'h3C);
    chk("t2_drop",      32'(bus.drop_cnt),      32'h0);

    // 3: self bit stripped, rest goes to the network
    bus.flit_ready = 1'b0;
    set_req(1'b1, 5'h07, 16'h0041, 8'h11);
    cyc();
    set_req(1'b0, 5'h0, 16'h0, 8'h0);
    chk("t3_local_valid", 32'(bus.local_valid), 32'h1);
    chk("t3_flit_out",    32'(bus.flit_out),    32'h0E000223);
    bus.flit_ready = 1'b1;
    cyc();
    chk("t3_popped", 32'(bus.flit_valid), 32'h0);

    // 4: fill under backpressure, then drain in order
    bus.flit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 5'(i + 1), 16'h1000 | 16'(i), 8'h50 + 8'(i));
      #1;
      chk("t4_req_ready", 32'(bus.req_ready), (i < 4) ? 32'h1 : 32'h0);
      cyc();
    end
    set_req(1'b0, 5'h0, 16'h0, 8'h0);
    chk("t4_head", 32'(bus.flit_out), {2'b0, 5'h01, 16'h1000, 8'h50, 1'b1});
    bus.flit_ready = 1'b1;
    cyc();
    chk("t4_ready_back", 32'(bus.req_ready), 32'h1);
    chk("t4_second",     32'(bus.flit_out),  {2'b0, 5'h02, 16'h1001, 8'h51, 1'b1});
    for (int i = 0; i < 4; i++) cyc();
    chk("t4_drained", 32'(bus.flit_valid), 32'h0);

    // mixed traffic: simultaneous push/pop and self copies
    for (int i = 0; i < 8; i++) begin
      bus.flit_ready = (i % 3) != 0;
      set_req(1'b1, 5'(i + 9), (i % 2 == 0) ? 16'h0043 : 16'h8000, 8'(i * 17));
      cyc();
    end
    set_req(1'b0, 5'h0, 16'h0, 8'h0);
    bus.flit_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();

    // 5: drop counter saturation
    for (int i = 0; i < 300; i++) begin
      set_req(1'b1, 5'h1, 16'h0000, 8'hEE);
      cyc();
    end
    chk("t5_drop_sat", 32'(bus.drop_cnt), 32'hFF);
    cyc();
    set_req(1'b0, 5'h0, 16'h0, 8'h0);
    chk("t5_drop_hold", 32'(bus.drop_cnt),   32'hFF);
    chk("t5_no_flit",   32'(bus.flit_valid), 32'h0);

    // 6: reset with buffered flits
    bus.flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 5'h02, 16'h0200, 8'(i));
      cyc();
    end
    set_req(1'b0, 5'h0, 16'h0, 8'h0);
    chk("t6_filled", 32'(bus.flit_valid), 32'h1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_flit_valid", 32'(bus.flit_valid), 32'h0);
    chk("t6_flit_out",   32'(bus.flit_out),   32'h0);
    chk("t6_drop_cnt",   32'(bus.drop_cnt),   32'h0);
    set_req(1'b1, 5'h1F, 16'h8000, 8'hFF);
    cyc();
    set_req(1'b0, 5'h0, 16'h0, 8'h0);
    chk("t6_alone", 32'(bus.flit_out), 32'h3F0001FF);
    bus.flit_ready = 1'b1;
    cyc();
    chk("t6_empty", 32'(bus.flit_valid), 32'h0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
